wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter_pkg.sv | 24 ++
 rtl/wb_port_arbiter_if.sv | 29 ++
 rtl/wb_pend_fifo.sv | 64 ++++++
 rtl/wb_port_arbiter.sv | 123 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and encodings for the writeback port arbiter.
// Build option: WB_STARVE_GUARD_EN enables the ALU starvation guard.
package wb_port_arbiter_pkg;

   localparam int unsigned RegAddrW = 5;
   localparam int unsigned DataW    = 32;
   localparam int unsigned CntW     = 4;

   localparam logic SEL_MEM = 1'b0;
   localparam logic SEL_ALU = 1'b1;

   typedef enum logic [1:0] {
      StIdle,
      StMem,
      StAlu,
      StForce
   } arb_state_e;

   typedef struct packed {
      logic [RegAddrW-1:0] rd;
      logic [DataW-1:0]    data;
   } wb_req_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback bus between the memory/ALU requesters, the arbiter and the register file.
interface wb_port_arbiter_if;
   import wb_port_arbiter_pkg::*;

   logic                mem_valid;
   logic                mem_ready;
   logic [RegAddrW-1:0] mem_rd;
   logic [DataW-1:0]    mem_data;
   logic                alu_valid;
   logic                alu_ready;
   logic [RegAddrW-1:0] alu_rd;
   logic [DataW-1:0]    alu_data;
   logic                rf_we;
   logic [RegAddrW-1:0] rf_waddr;
   logic [DataW-1:0]    rf_wdata;
   logic                rf_sel;
   logic [CntW-1:0]     pend_cnt;

   modport slave (
      input  mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data,
      output mem_ready, alu_ready, rf_we, rf_waddr, rf_wdata, rf_sel, pend_cnt
   );

   modport master (
      output mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data,
      input  mem_ready, alu_ready, rf_we, rf_waddr, rf_wdata, rf_sel, pend_cnt
   );

endinterface

// File: rtl/wb_pend_fifo.sv
// Synchronous FIFO holding ALU writebacks that lost arbitration to memory.
module wb_pend_fifo
   import wb_port_arbiter_pkg::*;
#(
   parameter int unsigned Depth = 2
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            push_i,
   input  wb_req_t         wdata_i,
   input  logic            pop_i,
   output wb_req_t         rdata_o,
   output logic [CntW-1:0] count_o,
   output logic            full_o,
   output logic            empty_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
   localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

   wb_req_t         mem_q [Depth];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            push_en, pop_en;

   always_comb begin
      full_o   = (count_q == DepthCnt);
      empty_o  = (count_q == '0);
      push_en  = push_i & ~full_o;
      pop_en   = pop_i & ~empty_o;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_en) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      case ({push_en, pop_en})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Storage needs no reset: occupancy is tracked by count_q alone.
   always_ff @(posedge clk_i) begin
      if (push_en) mem_q[wr_ptr_q] <= wdata_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates memory and ALU writebacks onto one register-file write port.
// Build option: WB_STARVE_GUARD_EN forces a buffered ALU write after STARVE_MAX memory grants.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH      = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input logic               clk,
   input logic               rst_n,
   wb_port_arbiter_if.slave  bus
);

   wb_req_t             fifo_rdata, alu_req;
   logic                fifo_full, fifo_empty;
   logic [CntW-1:0]     pend_cnt;
   logic                alu_acc, mem_grant, pop, push, bypass, force_grant;
   arb_state_e          state_q, state_d;
   logic                wr_nz_q, wr_nz_d;
   logic [RegAddrW-1:0] rf_waddr_q, rf_waddr_d;
   logic [DataW-1:0]    rf_wdata_q, rf_wdata_d;
   logic                rf_sel_q, rf_sel_d;

`ifdef WB_STARVE_GUARD_EN
   localparam int unsigned StreakW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
   localparam logic [StreakW-1:0] StreakMax = StreakW'(STARVE_MAX);

   logic [StreakW-1:0] streak_q, streak_d;

   assign force_grant = (streak_q == StreakMax) && !fifo_empty;

   always_comb begin
      streak_d = streak_q;
      if ((pend_cnt == '0) || pop) begin
         streak_d = '0;
      end else if (mem_grant && (streak_q != StreakMax)) begin
         streak_d = streak_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) streak_q <= '0;
      else        streak_q <= streak_d;
   end
`else
   assign force_grant = 1'b0;
`endif

   assign alu_req   = '{rd: bus.alu_rd, data: bus.alu_data};
   assign alu_acc   = bus.alu_valid & ~fifo_full;
   assign mem_grant = bus.mem_valid & ~force_grant;
   assign pop       = ~mem_grant & ~fifo_empty;
   // An accepted ALU request skips the FIFO only when nothing older is waiting.
   assign bypass    = ~mem_grant & fifo_empty & alu_acc;
   assign push      = alu_acc & ~bypass;

   wb_pend_fifo #(
      .Depth (DEPTH)
   ) u_pend_fifo (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .push_i  (push),
      .wdata_i (alu_req),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .count_o (pend_cnt),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      state_d    = StIdle;
      wr_nz_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      rf_sel_d   = rf_sel_q;
      if (mem_grant) begin
         state_d    = StMem;
         wr_nz_d    = |bus.mem_rd;
         rf_waddr_d = bus.mem_rd;
         rf_wdata_d = bus.mem_data;
         rf_sel_d   = SEL_MEM;
      end else if (pop) begin
         state_d    = force_grant ? StForce : StAlu;
         wr_nz_d    = |fifo_rdata.rd;
         rf_waddr_d = fifo_rdata.rd;
         rf_wdata_d = fifo_rdata.data;
         rf_sel_d   = SEL_ALU;
      end else if (bypass) begin
         state_d    = StAlu;
         wr_nz_d    = |bus.alu_rd;
         rf_waddr_d = bus.alu_rd;
         rf_wdata_d = bus.alu_data;
         rf_sel_d   = SEL_ALU;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         wr_nz_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         rf_sel_q   <= SEL_MEM;
      end else begin
         state_q    <= state_d;
         wr_nz_q    <= wr_nz_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         rf_sel_q   <= rf_sel_d;
      end
   end

   // A grant to r0 still occupies the slot but must not write.
   assign bus.rf_we     = (state_q != StIdle) & wr_nz_q;
   assign bus.rf_waddr  = rf_waddr_q;
   assign bus.rf_wdata  = rf_wdata_q;
   assign bus.rf_sel    = rf_sel_q;
   assign bus.pend_cnt  = pend_cnt;
   assign bus.alu_ready = ~fifo_full;
   assign bus.mem_ready = ~force_grant;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: vector table, guard sequence and reset sequence.
module tb_wb_port_arbiter;

   typedef struct {
      bit          mv;
      logic [4:0]  mrd;
      logic [31:0] mdat;
      bit          av;
      logic [4:0]  ard;
      logic [31:0] adat;
      bit          ar;
      bit          mr;
      bit          chk;
      bit          we;
      logic [4:0]  wa;
      logic [31:0] wd;
      bit          sel;
      logic [3:0]  pend;
   } vec_t;

   typedef struct {
      bit          chk;
      bit          we;
      logic [4:0]  wa;
      logic [31:0] wd;
      bit          sel;
      logic [3:0]  pend;
      string       tag;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   vec_t tbl[14];

   always #5 clk = ~clk;

   wb_port_arbiter_if bus ();

   wb_port_arbiter #(
      .DEPTH      (2),
      .STARVE_MAX (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic vec_t mk(input int mv, input int mrd, input int mdat, input int av,
                               input int ard, input int adat, input int ar, input int mr,
                               input int chk, input int we, input int wa, input int wd,
                               input int sel, input int pend);
      vec_t v;
      v.mv = 1'(mv);   v.mrd = 5'(mrd);  v.mdat = 32'(mdat);
      v.av = 1'(av);   v.ard = 5'(ard);  v.adat = 32'(adat);
      v.ar = 1'(ar);   v.mr = 1'(mr);    v.chk = 1'(chk);
      v.we = 1'(we);   v.wa = 5'(wa);    v.wd = 32'(wd);
      v.sel = 1'(sel); v.pend = 4'(pend);
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   task automatic drive_idle();
      bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
      bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
   endtask

   // Drive one cycle of stimulus, queue its expected writeback, then compare after the edge.
   task automatic apply(input vec_t v, input string tag);
      exp_t e;
      @(negedge clk);
      bus.mem_valid = v.mv; bus.mem_rd = v.mrd; bus.mem_data = v.mdat;
      bus.alu_valid = v.av; bus.alu_rd = v.ard; bus.alu_data = v.adat;
      #1;
      check({tag, ".alu_ready"}, 32'(bus.alu_ready), 32'(v.ar));
      check({tag, ".mem_ready"}, 32'(bus.mem_ready), 32'(v.mr));
      e.chk = v.chk; e.we = v.we; e.wa = v.wa; e.wd = v.wd; e.sel = v.sel; e.pend = v.pend;
      e.tag = tag;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++; errors++;
         $display("FAIL %s.scoreboard: got empty queue expected one entry", tag);
      end else begin
         e = exp_q.pop_front();
         check({e.tag, ".rf_we"}, 32'(bus.rf_we), 32'(e.we));
         check({e.tag, ".pend_cnt"}, 32'(bus.pend_cnt), 32'(e.pend));
         if (e.chk) begin
            check({e.tag, ".rf_waddr"}, 32'(bus.rf_waddr), 32'(e.wa));
            check({e.tag, ".rf_wdata"}, bus.rf_wdata, e.wd);
            check({e.tag, ".rf_sel"}, 32'(bus.rf_sel), 32'(e.sel));
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".rf_we"}, 32'(bus.rf_we), 32'd0);
      check({tag, ".rf_waddr"}, 32'(bus.rf_waddr), 32'd0);
      check({tag, ".rf_wdata"}, bus.rf_wdata, 32'd0);
      check({tag, ".rf_sel"}, 32'(bus.rf_sel), 32'd0);
      check({tag, ".pend_cnt"}, 32'(bus.pend_cnt), 32'd0);
   endtask

   initial begin
      //          mv mrd mdat    av ard adat    ar mr ck we wa wd       sel pend
      tbl[0]  = mk(0, 0, 0,      1, 5,  'h1234, 1, 1, 1, 1, 5, 'h1234, 1,  0);
      tbl[1]  = mk(0, 0, 0,      0, 0,  0,      1, 1, 1, 0, 5, 'h1234, 1,  0);
      tbl[2]  = mk(1, 7, 'hCAFE, 0, 0,  0,      1, 1, 1, 1, 7, 'hCAFE, 0,  0);
      tbl[3]  = mk(1, 3, 'hAAAA, 1, 4,  'hBBBB, 1, 1, 1, 1, 3, 'hAAAA, 0,  1);
      tbl[4]  = mk(0, 0, 0,      0, 0,  0,      1, 1, 1, 1, 4, 'hBBBB, 1,  0);
      tbl[5]  = mk(1, 1, 'h11,   1, 10, 'hA0,   1, 1, 1, 1, 1, 'h11,   0,  1);
      tbl[6]  = mk(1, 1, 'h12,   1, 11, 'hA1,   1, 1, 1, 1, 1, 'h12,   0,  2);
      tbl[7]  = mk(1, 1, 'h13,   1, 12, 'hA2,   0, 1, 1, 1, 1, 'h13,   0,  2);
      tbl[8]  = mk(0, 0, 0,      1, 12, 'hA2,   0, 1, 1, 1, 10, 'hA0,  1,  1);
      tbl[9]  = mk(0, 0, 0,      1, 12, 'hA2,   1, 1, 1, 1, 11, 'hA1,  1,  1);
      tbl[10] = mk(0, 0, 0,      0, 0,  0,      1, 1, 1, 1, 12, 'hA2,  1,  0);
      tbl[11] = mk(0, 0, 0,      1, 0,  'h55,   1, 1, 0, 0, 0, 0,      0,  0);
      tbl[12] = mk(1, 0, 'h66,   0, 0,  0,      1, 1, 0, 0, 0, 0,      0,  0);
      tbl[13] = mk(1, 2, 'h22,   0, 0,  0,      1, 1, 1, 1, 2, 'h22,   0,  0);

      rst_n = 1'b0;
      drive_idle();
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("in_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_reset_outputs("after_reset");
      check("after_reset.alu_ready", 32'(bus.alu_ready), 32'd1);
      check("after_reset.mem_ready", 32'(bus.mem_ready), 32'd1);

      for (int i = 0; i < 14; i++) apply(tbl[i], $sformatf("vec%0d", i));

      // Memory held high with one ALU write buffered behind it.
      apply(mk(1, 8, 'h80, 1, 9, 'h90, 1, 1, 1, 1, 8, 'h80, 0, 1), "guard_setup");
      for (int i = 1; i <= 4; i++) begin
         apply(mk(1, 8, 'h80 + i, 0, 0, 0, 1, 1, 1, 1, 8, 'h80 + i, 0, 1),
               $sformatf("guard_mem%0d", i));
      end
`ifdef WB_STARVE_GUARD_EN
      apply(mk(1, 8, 'h85, 0, 0, 0, 1, 0, 1, 1, 9, 'h90, 1, 0), "guard_force");
      apply(mk(1, 8, 'h86, 0, 0, 0, 1, 1, 1, 1, 8, 'h86, 0, 0), "guard_resume");
`else
      apply(mk(1, 8, 'h85, 0, 0, 0, 1, 1, 1, 1, 8, 'h85, 0, 1), "guard_mem5");
      apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 9, 'h90, 1, 0), "guard_drain");
`endif

      // Fill the buffer, then reset mid-cycle: nothing buffered may come out afterwards.
      apply(mk(1, 1, 'h31, 1, 20, 'h40, 1, 1, 1, 1, 1, 'h31, 0, 1), "rst_fill1");
      apply(mk(1, 1, 'h32, 1, 21, 'h41, 1, 1, 1, 1, 1, 'h32, 0, 2), "rst_fill2");
      @(negedge clk);
      drive_idle();
      #1 rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      check("mid_reset.alu_ready", 32'(bus.alu_ready), 32'd1);
      #1 rst_n = 1'b1;
      apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0), "post_reset1");
      apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0), "post_reset2");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
